load_store_unit: RTL and testbench



---
 rtl/lsu_pkg.sv | 48 ++++
 rtl/lsu_align.sv | 63 ++++++
 rtl/load_store_unit.sv | 148 ++++++++++++++
 tb/tb_load_store_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types, RV32I funct3 encodings, FSM states and request-decode helpers
// for the load/store unit.
package lsu_pkg;

  localparam int DATA_W     = 32;
  localparam int LSU_ADDR_W = 32;

  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [LSU_ADDR_W-1:0] addr_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } lsu_state_t;

  // Stores only exist for the three signed-size codes.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    case (f3)
      F3_LB, F3_LH, F3_LW: bad = 1'b0;
      F3_LBU, F3_LHU:      bad = we;
      default:             bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane formatting: store byte enables / replicated write data and
// load lane extract with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] off,
  input  data_t      wdata,
  input  data_t      rdata,
  output logic [3:0] wen,
  output data_t      wd,
  output data_t      ldata
);

  logic [1:0]  lane;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Misaligned low bits are dropped here, so unaligned halves/words fall back
  // to their naturally aligned lane.
  always_comb begin
    case (funct3[1:0])
      2'b00:   lane = off;
      2'b01:   lane = {off[1], 1'b0};
      default: lane = 2'b00;
    endcase
    byte_sel = rdata[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (funct3)
      F3_SB: begin
        wen = 4'b0001 << lane;
        wd  = {4{wdata[7:0]}};
      end
      F3_SH: begin
        wen = lane[1] ? 4'b1100 : 4'b0011;
        wd  = {2{wdata[15:0]}};
      end
      F3_SW: begin
        wen = 4'b1111;
        wd  = wdata;
      end
      default: begin
        wen = 4'b0000;
        wd  = 32'h0000_0000;
      end
    endcase
  end

  always_comb begin
    case (funct3)
      F3_LB:   ldata = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  ldata = {24'h00_0000, byte_sel};
      F3_LH:   ldata = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  ldata = {16'h0000, half_sel};
      F3_LW:   ldata = rdata;
      default: ldata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: IDLE/MEM/WAIT/RESP sequencer towards a one-cycle-latency
// data memory. Define LSU_MISALIGN_TRAP_EN to reject misaligned halves/words.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int    ADDR_W      = 32,
  parameter data_t RESET_RDATA = 32'h0000_0000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_funct3,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  output logic [ADDR_W-1:0] o_DM_addr,
  output logic [31:0]       o_DM_wd,
  output logic [3:0]        o_DM_wen,
  output logic              o_DM_ren,
  input  logic [31:0]       i_DM_rd
);

  lsu_state_t state;
  logic       we_r;
  logic [2:0] funct3_r;
  logic [1:0] off_r;

  logic       accept;
  logic       illegal;
  logic       misaligned;
  logic       skip;
  logic [2:0] fmt_funct3;
  logic [1:0] fmt_off;
  logic [3:0] fmt_wen;
  data_t      fmt_wd;
  data_t      fmt_ldata;

  // One formatter serves both directions: live request while IDLE, latched request afterwards.
  always_comb begin
    accept  = i_req_valid & o_req_ready;
    illegal = f3_illegal(i_req_we, i_req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = f3_misaligned(i_req_funct3, i_req_addr[1:0]);
`else
    misaligned = 1'b0;
`endif
    skip = illegal | misaligned;
    if (state == S_IDLE) begin
      fmt_funct3 = i_req_funct3;
      fmt_off    = i_req_addr[1:0];
    end else begin
      fmt_funct3 = funct3_r;
      fmt_off    = off_r;
    end
  end

  lsu_align u_align (
    .funct3 (fmt_funct3),
    .off    (fmt_off),
    .wdata  (i_req_wdata),
    .rdata  (i_DM_rd),
    .wen    (fmt_wen),
    .wd     (fmt_wd),
    .ldata  (fmt_ldata)
  );

  // Sequencer with all outputs registered; reset kills any pending write enable at once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_IDLE;
      we_r        <= 1'b0;
      funct3_r    <= 3'b000;
      off_r       <= 2'b00;
      o_req_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      o_rsp_rdata <= RESET_RDATA;
      o_DM_addr   <= {ADDR_W{1'b0}};
      o_DM_wd     <= 32'h0000_0000;
      o_DM_wen    <= 4'b0000;
      o_DM_ren    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            we_r        <= i_req_we;
            funct3_r    <= i_req_funct3;
            off_r       <= i_req_addr[1:0];
            o_req_ready <= 1'b0;
            if (skip) begin
              state       <= S_RESP;
              o_rsp_valid <= 1'b1;
              o_rsp_err   <= 1'b1;
              o_rsp_rdata <= RESET_RDATA;
            end else begin
              state     <= S_MEM;
              o_DM_addr <= {i_req_addr[ADDR_W-1:2], 2'b00};
              o_DM_wd   <= i_req_we ? fmt_wd : 32'h0000_0000;
              o_DM_wen  <= i_req_we ? fmt_wen : 4'b0000;
              o_DM_ren  <= ~i_req_we;
            end
          end
        end
        S_MEM: begin
          o_DM_wen <= 4'b0000;
          o_DM_ren <= 1'b0;
          if (we_r) begin
            state       <= S_RESP;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b0;
            o_rsp_rdata <= RESET_RDATA;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          state       <= S_RESP;
          o_rsp_valid <= 1'b1;
          o_rsp_err   <= 1'b0;
          o_rsp_rdata <= fmt_ldata;
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            state       <= S_IDLE;
            o_req_ready <= 1'b1;
            o_rsp_valid <= 1'b0;
            o_rsp_err   <= 1'b0;
            o_rsp_rdata <= RESET_RDATA;
          end
        end
        default: begin
          state       <= S_IDLE;
          o_req_ready <= 1'b1;
          o_rsp_valid <= 1'b0;
          o_rsp_err   <= 1'b0;
          o_DM_wen    <= 4'b0000;
          o_DM_ren    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a byte-lane memory model
// and a transaction-level reference model.
module tb_load_store_unit;

  logic        i_clk;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [2:0]  i_req_funct3;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [31:0] o_DM_addr;
  logic [31:0] o_DM_wd;
  logic [3:0]  o_DM_wen;
  logic        o_DM_ren;
  logic [31:0] i_DM_rd;

  logic [31:0] mem       [0:63];
  logic [31:0] model_mem [0:63];
  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_we     (i_req_we),
    .i_req_funct3 (i_req_funct3),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_rdata  (o_rsp_rdata),
    .o_rsp_err    (o_rsp_err),
    .o_DM_addr    (o_DM_addr),
    .o_DM_wd      (o_DM_wd),
    .o_DM_wen     (o_DM_wen),
    .o_DM_ren     (o_DM_ren),
    .i_DM_rd      (i_DM_rd)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Data memory: read data one cycle after ren, byte-lane writes.
  always @(posedge i_clk) begin
    if (o_DM_ren) i_DM_rd <= mem[o_DM_addr[7:2]];
    for (int i = 0; i < 4; i++)
      if (o_DM_wen[i]) mem[o_DM_addr[7:2]][8*i +: 8] <= o_DM_wd[8*i +: 8];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what one request must produce, from size/offset arithmetic.
  task automatic model_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] word,
                           output logic err, output logic skip, output logic [31:0] rdata,
                           output logic [3:0] wen, output logic [31:0] wd,
                           output logic [31:0] new_word);
    int sz, base;
    logic legal;
    logic [31:0] mask;
    legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
    sz    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    base  = int'(addr[1:0]) - (int'(addr[1:0]) % sz);
    skip  = !legal;
    err   = !legal;
`ifdef LSU_MISALIGN_TRAP_EN
    if (legal && (int'(addr[1:0]) % sz) != 0) begin
      skip = 1'b1;
      err  = 1'b1;
    end
`endif
    rdata = 32'h0; wen = 4'h0; wd = 32'h0; new_word = word;
    if (!skip && we) begin
      for (int i = 0; i < sz; i++) begin
        wen[base+i] = 1'b1;
        new_word[8*(base+i) +: 8] = wdata[8*i +: 8];
      end
      wd = (sz == 1) ? {4{wdata[7:0]}} : (sz == 2) ? {2{wdata[15:0]}} : wdata;
    end
    if (!skip && !we) begin
      rdata = word >> (8*base);
      if (sz < 4) begin
        mask  = (32'h1 << (8*sz)) - 32'h1;
        rdata = rdata & mask;
        if (!f3[2] && rdata[8*sz-1]) rdata = rdata | ~mask;
      end
    end
  endtask

  // Drive one request and compare every output on every cycle until the handshake completes.
  task automatic run_txn(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    logic err, skip;
    logic [31:0] rdata, wd, new_word;
    logic [3:0] wen;
    int idx, lat;
    idx = int'(addr[7:2]);
    model_txn(we, f3, addr, wdata, model_mem[idx], err, skip, rdata, wen, wd, new_word);
    lat = skip ? 1 : (we ? 2 : 3);
    @(negedge i_clk);
    chk({tag, "_ready_idle"}, {31'd0, o_req_ready}, 32'd1);
    i_req_valid = 1'b1; i_req_we = we; i_req_funct3 = f3;
    i_req_addr = addr; i_req_wdata = wdata; i_rsp_ready = 1'b0;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    for (int k = 1; k <= lat + hold; k++) begin
      if (k > 1) @(negedge i_clk);
      chk({tag, "_ready_busy"}, {31'd0, o_req_ready}, 32'd0);
      chk({tag, "_wen"}, {28'd0, o_DM_wen}, (k == 1) ? {28'd0, wen} : 32'd0);
      chk({tag, "_ren"}, {31'd0, o_DM_ren}, {31'd0, (k == 1) && !skip && !we});
      if (k == 1 && !skip) chk({tag, "_dm_addr"}, o_DM_addr, {addr[31:2], 2'b00});
      if (k == 1 && !skip && we) chk({tag, "_dm_wd"}, o_DM_wd, wd);
      chk({tag, "_rsp_valid"}, {31'd0, o_rsp_valid}, {31'd0, k >= lat});
      if (k >= lat) begin
        chk({tag, "_rdata"}, o_rsp_rdata, rdata);
        chk({tag, "_err"}, {31'd0, o_rsp_err}, {31'd0, err});
      end
      if (k == lat + hold) i_rsp_ready = 1'b1;
    end
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
    chk({tag, "_rsp_done"}, {31'd0, o_rsp_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, o_req_ready}, 32'd1);
    model_mem[idx] = new_word;
    chk({tag, "_mem"}, mem[idx], model_mem[idx]);
  endtask

  initial begin
    logic e, s;
    logic [31:0] r, w, nw;
    logic [3:0] we4;

    i_rst = 1'b1; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_funct3 = 3'd0;
    i_req_addr = 32'h0; i_req_wdata = 32'h0; i_rsp_ready = 1'b0;

    #12;
    chk("rst_ready", {31'd0, o_req_ready}, 32'd1);
    chk("rst_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("rst_err",   {31'd0, o_rsp_err}, 32'd0);
    chk("rst_rdata", o_rsp_rdata, 32'h0);
    chk("rst_wen",   {28'd0, o_DM_wen}, 32'd0);
    chk("rst_ren",   {31'd0, o_DM_ren}, 32'd0);
    chk("rst_addr",  o_DM_addr, 32'h0);
    chk("rst_wd",    o_DM_wd, 32'h0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Pin the model against hand-computed values.
    model_txn(1'b1, 3'b000, 32'h103, 32'hA5, 32'h0, e, s, r, we4, w, nw);
    chk("pin_sb_wen", {28'd0, we4}, 32'h8);
    chk("pin_sb_wd", w, 32'hA5A5A5A5);
    model_txn(1'b0, 3'b000, 32'h102, 32'h0, 32'h80FF7F01, e, s, r, we4, w, nw);
    chk("pin_lb", r, 32'hFFFFFFFF);
    model_txn(1'b0, 3'b100, 32'h102, 32'h0, 32'h80FF7F01, e, s, r, we4, w, nw);
    chk("pin_lbu", r, 32'h000000FF);
    model_txn(1'b0, 3'b001, 32'h102, 32'h0, 32'h80001234, e, s, r, we4, w, nw);
    chk("pin_lh", r, 32'hFFFF8000);
    model_txn(1'b0, 3'b101, 32'h102, 32'h0, 32'h80001234, e, s, r, we4, w, nw);
    chk("pin_lhu", r, 32'h00008000);
    model_txn(1'b0, 3'b010, 32'h101, 32'h0, 32'h12345678, e, s, r, we4, w, nw);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("pin_lw_mis_err", {31'd0, e}, 32'd1);
`else
    chk("pin_lw_mis_rd", r, 32'h12345678);
`endif

    run_txn("sw100", 1'b1, 3'b010, 32'h100, 32'h80FF7F01, 0);
    run_txn("lb102", 1'b0, 3'b000, 32'h102, 32'h0, 0);
    run_txn("lbu102", 1'b0, 3'b100, 32'h102, 32'h0, 0);
    run_txn("sb103", 1'b1, 3'b000, 32'h103, 32'h000000A5, 0);
    run_txn("sw104", 1'b1, 3'b010, 32'h104, 32'h80001234, 0);
    run_txn("lh106", 1'b0, 3'b001, 32'h106, 32'h0, 0);
    run_txn("lhu106", 1'b0, 3'b101, 32'h106, 32'h0, 0);
    run_txn("lw101", 1'b0, 3'b010, 32'h101, 32'h0, 0);
    run_txn("sw108", 1'b1, 3'b010, 32'h108, 32'h11223344, 0);
    run_txn("sh10a", 1'b1, 3'b001, 32'h10A, 32'h0000BEEF, 0);
    run_txn("lb108", 1'b0, 3'b000, 32'h108, 32'h0, 0);
    run_txn("lh109", 1'b0, 3'b001, 32'h109, 32'h0, 0);
    run_txn("lhu10b", 1'b0, 3'b101, 32'h10B, 32'h0, 0);
    run_txn("sb109", 1'b1, 3'b000, 32'h109, 32'h00000080, 0);
    run_txn("lb109", 1'b0, 3'b000, 32'h109, 32'h0, 0);
    run_txn("ill_l3", 1'b0, 3'b011, 32'h100, 32'h0, 0);
    run_txn("ill_l6", 1'b0, 3'b110, 32'h100, 32'h0, 0);
    run_txn("ill_l7", 1'b0, 3'b111, 32'h100, 32'h0, 0);
    run_txn("ill_s4", 1'b1, 3'b100, 32'h100, 32'hDEADBEEF, 0);
    run_txn("lw_hold", 1'b0, 3'b010, 32'h104, 32'h0, 5);

    // Reset asserted while a store sits in MEM.
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_funct3 = 3'b000;
    i_req_addr = 32'h104; i_req_wdata = 32'h0000005A;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    chk("rstmem_wen_pre", {28'd0, o_DM_wen}, 32'h1);
    i_rst = 1'b1;
    #1;
    chk("rstmem_wen", {28'd0, o_DM_wen}, 32'd0);
    chk("rstmem_ready", {31'd0, o_req_ready}, 32'd1);
    chk("rstmem_valid", {31'd0, o_rsp_valid}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("rstmem_word", mem[1], 32'h80001234);
    run_txn("lw_after_rst", 1'b0, 3'b010, 32'h104, 32'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
